// File: rtl/vga_pkg.sv
// Shared VGA constants and types.
// Holds the 640x480 timing defaults, the RGB444 pixel width, framebuffer
// address width and the per-stage record carried down the display pipeline.
package vga_pkg;

  localparam int unsigned HVisibleDef = 640;
  localparam int unsigned HFrontDef   = 16;
  localparam int unsigned HSyncDef    = 96;
  localparam int unsigned VVisibleDef = 480;
  localparam int unsigned VFrontDef   = 10;
  localparam int unsigned VSyncDef    = 2;

  localparam int unsigned RgbW   = 12;  // RGB444 packed as {r, g, b}
  localparam int unsigned AddrW  = 19;
  localparam int unsigned CoordW = 10;

  typedef struct packed {
    logic visible;
    logic hsync_n;
    logic vsync_n;
  } pipe_t;

  // Invisible pixel with both syncs inactive.
  localparam pipe_t PipeIdle = '{visible: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1};

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data.
// Ports: clk_i/rst_ni clock and async active-low reset; push_i/data_i write;
// pop_i read; data_o head entry; empty_o/full_o status.
// A push on a full FIFO is accepted only when a pop frees a slot in the same
// cycle; otherwise it is dropped. Depth must be a power of two >= 2.
module sync_fifo #(
  parameter int unsigned Width = 12,
  parameter int unsigned Depth = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] PtrOne = {{PtrW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PtrW:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  always_comb begin
    empty_o  = (wr_ptr_q == rd_ptr_q);
    full_o   = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
               (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + PtrOne : rd_ptr_q;
    data_o   = mem_q[rd_ptr_q[PtrW-1:0]];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; resetting the pointers discards the contents.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[PtrW-1:0]] <= data_i;
  end

endmodule

// File: rtl/vga_fb_display.sv
// Framebuffer-backed VGA display back end.
// Ports: clk/reset pixel clock and async active-low reset; enable pixel tick
// qualifying column/row from an external pixel counter; mem_rd_* framebuffer
// read request/response (RGB444); vga_* registered sync (active low) and
// colour; underflow/overflow sticky pixel-FIFO error flags.
// Each visible pixel issues one read; the returned word is buffered in a FIFO
// and popped PIPE_DEPTH ticks later, aligned with the delayed sync signals.
module vga_fb_display
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = HVisibleDef,
  parameter int unsigned H_FRONT    = HFrontDef,
  parameter int unsigned H_SYNC     = HSyncDef,
  parameter int unsigned V_VISIBLE  = VVisibleDef,
  parameter int unsigned V_FRONT    = VFrontDef,
  parameter int unsigned V_SYNC     = VSyncDef,
  parameter int unsigned PIPE_DEPTH = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [CoordW-1:0] column,
  input  logic [CoordW-1:0] row,
  output logic              mem_rd_req,
  output logic [AddrW-1:0]  mem_rd_addr,
  input  logic              mem_rd_valid,
  input  logic [RgbW-1:0]   mem_rd_data,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic [3:0]        vga_red,
  output logic [3:0]        vga_green,
  output logic [3:0]        vga_blue,
  output logic              underflow,
  output logic              overflow
);

  localparam logic [CoordW-1:0] HVisEnd  = CoordW'(H_VISIBLE);
  localparam logic [CoordW-1:0] HSyncLo  = CoordW'(H_VISIBLE + H_FRONT);
  localparam logic [CoordW-1:0] HSyncHi  = CoordW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CoordW-1:0] VVisEnd  = CoordW'(V_VISIBLE);
  localparam logic [CoordW-1:0] VSyncLo  = CoordW'(V_VISIBLE + V_FRONT);
  localparam logic [CoordW-1:0] VSyncHi  = CoordW'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [AddrW-1:0]  AddrOne  = {{(AddrW - 1){1'b0}}, 1'b1};

  pipe_t            stage_in, tail;
  pipe_t            pipe_q [PIPE_DEPTH];
  logic             frame_start;
  logic [AddrW-1:0] cur_addr, addr_cnt_q, addr_cnt_d, rd_addr_q, rd_addr_d;
  logic             rd_req_q, rd_req_d;
  logic             hsync_q, vsync_q;
  logic [RgbW-1:0]  rgb_q, rgb_d;
  logic             underflow_q, overflow_q;
  logic             fifo_pop, fifo_empty, fifo_full;
  logic [RgbW-1:0]  fifo_data;

  always_comb begin
    stage_in         = PipeIdle;
    stage_in.visible = (column < HVisEnd) && (row < VVisEnd);
    stage_in.hsync_n = !((column >= HSyncLo) && (column < HSyncHi));
    stage_in.vsync_n = !((row >= VSyncLo) && (row < VSyncHi));
    tail             = pipe_q[PIPE_DEPTH-1];

    // Frame start forces the address to 0 so a mid-frame reset or a lost
    // tick cannot leave the read address permanently skewed.
    frame_start = (column == '0) && (row == '0);
    cur_addr    = frame_start ? '0 : addr_cnt_q;
    rd_req_d    = enable && stage_in.visible;
    rd_addr_d   = rd_req_d ? cur_addr : rd_addr_q;
    addr_cnt_d  = addr_cnt_q;
    if (enable) addr_cnt_d = rd_req_d ? cur_addr + AddrOne : cur_addr;

    fifo_pop = enable && tail.visible && !fifo_empty;
    rgb_d    = fifo_pop ? fifo_data : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < PIPE_DEPTH; i++) pipe_q[i] <= PipeIdle;
      addr_cnt_q  <= '0;
      rd_addr_q   <= '0;
      rd_req_q    <= 1'b0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      rgb_q       <= '0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      rd_req_q   <= rd_req_d;
      rd_addr_q  <= rd_addr_d;
      addr_cnt_q <= addr_cnt_d;
      if (enable) begin
        pipe_q[0] <= stage_in;
        for (int unsigned i = 1; i < PIPE_DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        hsync_q <= tail.hsync_n;
        vsync_q <= tail.vsync_n;
        rgb_q   <= rgb_d;
        if (tail.visible && fifo_empty) underflow_q <= 1'b1;
      end
      // A pop in the same cycle frees a slot, so only a truly blocked push
      // counts as an overflow.
      if (mem_rd_valid && fifo_full && !fifo_pop) overflow_q <= 1'b1;
    end
  end

  sync_fifo #(
    .Width(RgbW),
    .Depth(FIFO_DEPTH)
  ) u_pixel_fifo (
    .clk_i  (clk),
    .rst_ni (reset),
    .push_i (mem_rd_valid),
    .data_i (mem_rd_data),
    .pop_i  (fifo_pop),
    .data_o (fifo_data),
    .empty_o(fifo_empty),
    .full_o (fifo_full)
  );

  assign mem_rd_req  = rd_req_q;
  assign mem_rd_addr = rd_addr_q;
  assign vga_hsync   = hsync_q;
  assign vga_vsync   = vsync_q;
  assign vga_red     = rgb_q[11:8];
  assign vga_green   = rgb_q[7:4];
  assign vga_blue    = rgb_q[3:0];
  assign underflow   = underflow_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_vga_fb_display.sv
// Self-checking bench for vga_fb_display (default 640x480 timing).
// A small memory model answers each read request two cycles later with
// addr[11:0]; expected pixels are queued at stimulus time and compared as the
// DUT produces them.
module tb_vga_fb_display;

  localparam int P = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [9:0]  column = '0;
  logic [9:0]  row = '0;
  logic        mem_rd_req;
  logic [18:0] mem_rd_addr;
  logic        mem_rd_valid = 1'b0;
  logic [11:0] mem_rd_data = '0;
  logic        vga_hsync, vga_vsync;
  logic [3:0]  vga_red, vga_green, vga_blue;
  logic        underflow, overflow;

  vga_fb_display dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .column      (column),
    .row         (row),
    .mem_rd_req  (mem_rd_req),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_valid(mem_rd_valid),
    .mem_rd_data (mem_rd_data),
    .vga_hsync   (vga_hsync),
    .vga_vsync   (vga_vsync),
    .vga_red     (vga_red),
    .vga_green   (vga_green),
    .vga_blue    (vga_blue),
    .underflow   (underflow),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        sets_under;
  } exp_t;

  typedef struct {
    int row;
    int lo;
    int hi;
    bit stall;
    int reqs;
    int first;
    int hs_low;
    int vs_low;
  } seg_t;

  exp_t        exp_q[$];
  exp_t        last_exp;
  logic [11:0] mfifo[$];
  int          n_pass = 0;
  int          n_total = 0;
  bit          mem_on = 1'b0;
  bit          inj_v = 1'b0;
  logic [11:0] inj_d = '0;
  bit          dl_v[2];
  logic [11:0] dl_d[2];
  int          m_addr = 0;
  bit          exp_under = 1'b0;
  bit          exp_over = 1'b0;
  int          seg_reqs, seg_first, seg_hs, seg_vs;
  seg_t        segs[10];

  function automatic exp_t idle_exp();
    exp_t e;
    e.rgb = '0; e.hs = 1'b1; e.vs = 1'b1; e.sets_under = 1'b0;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic prime();
    exp_q.delete();
    mfifo.delete();
    for (int i = 0; i < P; i++) exp_q.push_back(idle_exp());
    last_exp = idle_exp();
    m_addr = 0; exp_under = 1'b0; exp_over = 1'b0;
    dl_v[0] = 1'b0; dl_v[1] = 1'b0; dl_d[0] = '0; dl_d[1] = '0;
  endtask

  // One clock: drive inputs, queue the expected pixel, clock, run the memory
  // model, then compare the registered outputs.
  task automatic cycle(input bit en, input int col, input int rw);
    exp_t        e;
    bit          vis, v;
    logic [11:0] d;
    enable = en; column = 10'(col); row = 10'(rw);
    if (en) begin
      vis = (col < 640) && (rw < 480);
      e.hs = !((col >= 656) && (col < 752));
      e.vs = !((rw >= 490) && (rw < 492));
      e.rgb = '0; e.sets_under = 1'b0;
      if (col == 0 && rw == 0) m_addr = 0;
      if (vis) begin
        if (mem_on) e.rgb = 12'(m_addr);
        else if (mfifo.size() > 0) e.rgb = mfifo.pop_front();
        else e.sets_under = 1'b1;
        m_addr++;
      end
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    v = mem_on && dl_v[1];
    d = v ? dl_d[1] : 12'h0;
    dl_v[1] = dl_v[0]; dl_d[1] = dl_d[0];
    dl_v[0] = mem_rd_req; dl_d[0] = mem_rd_addr[11:0];
    if (inj_v) begin
      v = 1'b1; d = inj_d;
      if (mfifo.size() < 8) mfifo.push_back(d);
      else exp_over = 1'b1;
    end
    mem_rd_valid = v; mem_rd_data = d;
    if (mem_rd_req) begin
      seg_reqs++;
      if (seg_first < 0) seg_first = int'(mem_rd_addr);
    end
    if (en) begin
      last_exp = exp_q.pop_front();
      if (last_exp.sets_under) exp_under = 1'b1;
      if (!vga_hsync) seg_hs++;
      if (!vga_vsync) seg_vs++;
    end else begin
      check("req_when_disabled", 32'(mem_rd_req), 32'd0);
    end
    check("pixel", 32'({vga_red, vga_green, vga_blue, vga_hsync, vga_vsync, underflow}),
          32'({last_exp.rgb, last_exp.hs, last_exp.vs, exp_under}));
  endtask

  task automatic reset_dut(input string tag);
    reset = 1'b0; enable = 1'b0; inj_v = 1'b0;
    mem_rd_valid = 1'b0; mem_rd_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_hsync"}, 32'(vga_hsync), 32'd1);
    check({tag, "_vsync"}, 32'(vga_vsync), 32'd1);
    check({tag, "_rgb"}, 32'({vga_red, vga_green, vga_blue}), 32'd0);
    check({tag, "_req"}, 32'(mem_rd_req), 32'd0);
    check({tag, "_addr"}, 32'(mem_rd_addr), 32'd0);
    check({tag, "_underflow"}, 32'(underflow), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    prime();
  endtask

  initial begin
    // {row, col_lo, col_hi, stall, requests, first addr, hsync-low, vsync-low}
    segs[0] = '{0,   0,   799, 1'b0, 640, 0,    96, 0};
    segs[1] = '{1,   0,   799, 1'b0, 640, 640,  96, 0};
    segs[2] = '{2,   0,   9,   1'b0, 10,  1280, 0,  0};
    segs[3] = '{479, 630, 799, 1'b0, 10,  1290, 96, 0};
    segs[4] = '{489, 0,   799, 1'b0, 0,   -1,   96, 0};
    segs[5] = '{490, 0,   799, 1'b0, 0,   -1,   96, 796};
    segs[6] = '{491, 0,   799, 1'b0, 0,   -1,   96, 800};
    segs[7] = '{492, 0,   799, 1'b0, 0,   -1,   96, 4};
    segs[8] = '{524, 790, 799, 1'b0, 0,   -1,   0,  0};
    segs[9] = '{0,   0,   9,   1'b1, 10,  0,    0,  0};

    reset_dut("rst");
    mem_on = 1'b1;
    for (int s = 0; s < 10; s++) begin
      seg_reqs = 0; seg_first = -1; seg_hs = 0; seg_vs = 0;
      for (int c = segs[s].lo; c <= segs[s].hi; c++) begin
        cycle(1'b1, c, segs[s].row);
        if (segs[s].stall) cycle(1'b0, c, segs[s].row);
      end
      check($sformatf("seg%0d_reqs", s), seg_reqs, segs[s].reqs);
      check($sformatf("seg%0d_first_addr", s), seg_first, segs[s].first);
      check($sformatf("seg%0d_hsync_low", s), seg_hs, segs[s].hs_low);
      check($sformatf("seg%0d_vsync_low", s), seg_vs, segs[s].vs_low);
    end
    check("main_underflow", 32'(underflow), 32'd0);
    check("main_overflow", 32'(overflow), 32'd0);

    // Nine pushes with no pops: the ninth is dropped and flags overflow.
    mem_on = 1'b0;
    reset_dut("rst2");
    for (int i = 0; i < 9; i++) begin
      inj_v = 1'b1; inj_d = 12'h101 + 12'(i);
      cycle(1'b0, 0, 0);
    end
    check("overflow_after_8", 32'(overflow), 32'd0);
    inj_v = 1'b0;
    cycle(1'b0, 0, 0);
    check("overflow_after_9", 32'(overflow), 32'(exp_over));
    // Drain: the first eight values come out in order, then underflow.
    for (int c = 0; c < 16; c++) cycle(1'b1, c, 0);
    check("overflow_sticky", 32'(overflow), 32'd1);
    check("underflow_after_drain", 32'(underflow), 32'd1);
    for (int i = 0; i < 3; i++) begin
      inj_v = 1'b1; inj_d = 12'h201 + 12'(i);
      cycle(1'b0, 16, 0);
    end
    inj_v = 1'b0;
    cycle(1'b0, 16, 0);

    // Mid-frame reset must flush the leftover FIFO entries.
    reset_dut("midrst");
    for (int c = 0; c < 10; c++) cycle(1'b1, c, 0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 10, 0);
    check("underflow_sticky", 32'(underflow), 32'd1);
    check("overflow_after_reset", 32'(overflow), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vga_fb_display.md
VGA_FB_DISPLAY -- requirements
Module: vga_fb_display

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16; H_SYNC, default 96; V_VISIBLE, default 480; V_FRONT, default 10; V_SYNC, default 2.
REQ-003 SHALL have parameter PIPE_DEPTH, default 4, pixel ticks between address request and pixel output.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, pixel FIFO entries (power of two).
REQ-005 SHALL have ports, in order:
 clk  input  1  pixel clock
 reset  input  1  asynchronous, active-low reset
 enable  input  1  pixel tick; qualifies column/row
 column  input  10  current column from pixel address counter
 row  input  10  current row from pixel address counter
 mem_rd_req  output  1  one-cycle framebuffer read request
 mem_rd_addr  output  19  framebuffer word address
 mem_rd_valid  input  1  read data valid
 mem_rd_data  input  12  RGB444 read data {r,g,b}
 vga_hsync  output  1  horizontal sync, active low
 vga_vsync  output  1  vertical sync, active low
 vga_red / vga_green / vga_blue  output  4 each  pixel colour
 underflow  output  1  sticky: visible pixel found FIFO empty
 overflow  output  1  sticky: read data arrived with FIFO full

Function
REQ-006 SHALL update all pipeline state only on cycles with enable=1, except FIFO push, which occurs on any cycle with mem_rd_valid=1.
REQ-007 SHALL compute visible = (column < H_VISIBLE) && (row < V_VISIBLE).
REQ-008 SHALL compute hsync_n low iff H_VISIBLE+H_FRONT <= column < H_VISIBLE+H_FRONT+H_SYNC (656..751 by default).
REQ-009 SHALL compute vsync_n low iff V_VISIBLE+V_FRONT <= row < V_VISIBLE+V_FRONT+V_SYNC (490..491 by default).
REQ-010 SHALL assert mem_rd_req for exactly one clock, registered, on the cycle after each enabled visible (column,row).
REQ-011 SHALL generate mem_rd_addr with an incrementing counter, no multiplier: 0 at column=0,row=0; +1 after each issued request; wraps to 0 at frame start.
REQ-012 SHALL delay visible, hsync_n and vsync_n through a PIPE_DEPTH-stage shift register advanced on enable.
REQ-013 SHALL, on an enabled tick with delayed visible=1, pop one FIFO entry and drive it onto vga_red/green/blue (registered).
REQ-014 SHALL drive RGB 0 on any tick with delayed visible=0.
REQ-015 SHALL, if delayed visible=1 and the FIFO is empty, drive RGB 0 and set underflow.
REQ-016 SHALL, if mem_rd_valid=1 and the FIFO is full, drop the data and set overflow; push and pop in the same cycle on a full FIFO SHALL succeed.
REQ-017 SHALL register vga_hsync/vga_vsync from the last pipeline stage, aligned with RGB.
REQ-018 SHALL clear underflow/overflow only by reset.
REQ-019 SHALL hold all outputs when enable=0; mem_rd_req SHALL be 0 on such cycles.

Reset
REQ-020 SHALL, while reset=0, force vga_hsync=1, vga_vsync=1, RGB=0, mem_rd_req=0, mem_rd_addr=0, underflow=0, overflow=0, FIFO empty, and all pipeline stages to invisible/sync-inactive.
REQ-021 SHALL, on reset asserted mid-frame, drop all FIFO contents and resynchronise address to the next column=0,row=0.

Structure
REQ-022 SHALL take timing default constants and the RGB444 width from shared package vga_pkg.
REQ-023 SHALL instantiate sub-module sync_fifo (width 12, depth FIFO_DEPTH) for pixel buffering.

Verification
REQ-024 Reset held 3 cycles -> hsync=1, vsync=1, RGB=0, mem_rd_req=0, addr=0, flags=0.
REQ-025 Counter input col 0..799 row 0, memory returns addr[11:0] after 2 cycles -> 640 requests with addr 0..639, RGB pixel n = n[11:0] PIPE_DEPTH ticks later, no flags.
REQ-026 Row 1 column 0 -> mem_rd_addr=640; row 479 column 639 -> 307199; row 0 next frame -> 0.
REQ-027 Column 656..751 -> vga_hsync low for exactly 96 ticks; row 490..491 -> vga_vsync low for 1600 ticks; both delayed PIPE_DEPTH+1 ticks from inputs.
REQ-028 Memory never asserts mem_rd_valid -> RGB 0 on visible pixels, underflow=1 on first visible output, remains 1.
REQ-029 Inject 9 mem_rd_valid pulses with no pops -> overflow=1, FIFO holds first 8 values; then reset=0 mid-frame -> all outputs at reset values.
